// File: rtl/serial_pkg.sv
// Line levels and state encoding shared by the serial transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } serial_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// Valid/ready word handshake between a producer (master) and the serial transmitter (slave).
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/bit_timer.sv
// Bit period timer: pulses bit_done on the last cycle of every CLKS_PER_BIT-cycle line bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;

  // With CLKS_PER_BIT=1 the terminal count is 0, so the counter never leaves 0.
  assign bit_done = !clear && (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || bit_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/serial_tx.sv
// Serial line transmitter: start bit, LSB-first data, optional even parity, stop bit; idle-high.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic        clk,
  input  logic        reset,
  serial_tx_if.slave  s_if,
  output logic        tx_out,
  output logic        busy
);
  localparam int BW = $clog2(WIDTH + 1);

  serial_state_e    state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             parity_q;
  logic [BW-1:0]    bit_idx_q;
  logic             tx_q;
  logic             busy_q;
  logic             ready_q;
  logic             bit_done;

  assign shift_d        = shift_q >> 1;
  assign tx_out         = tx_q;
  assign busy           = busy_q;
  assign s_if.ready_out = ready_q;

  // Timer held cleared while idle so every frame starts on a fresh bit period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_if.valid_in) begin
            state_q  <= START;
            shift_q  <= s_if.data_in;
            parity_q <= ^s_if.data_in;
            tx_q     <= START_LEVEL;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_d;
            if (bit_idx_q == BW'(WIDTH - 1)) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= LINE_IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_d[0];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= LINE_IDLE;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations checked every cycle against a frame-level line model.
`timescale 1ns/1ps
module tb_serial_tx;
  localparam int NDUT = 3;
  localparam int W_A [NDUT] = '{8, 8, 5};
  localparam int C_A [NDUT] = '{4, 4, 1};
  localparam int P_A [NDUT] = '{0, 1, 1};

  logic            clk;
  logic            reset;
  logic            valid;
  logic [7:0]      data;
  logic [NDUT-1:0] tx;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] ready;

  int tests = 0;
  int fails = 0;

  // Expected line level for every remaining cycle of the frame in flight, per DUT.
  bit mq [NDUT][$];
  bit lv [$];

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      serial_tx_if #(.WIDTH(W_A[gi])) bus ();
      assign bus.data_in  = data[W_A[gi]-1:0];
      assign bus.valid_in = valid;
      assign ready[gi]    = bus.ready_out;
      serial_tx #(
        .WIDTH       (W_A[gi]),
        .CLKS_PER_BIT(C_A[gi]),
        .PARITY_EN   (P_A[gi])
      ) u_dut (
        .clk   (clk),
        .reset (reset),
        .s_if  (bus.slave),
        .tx_out(tx[gi]),
        .busy  (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Line model: an accepted word expands into its list of line levels, each repeated CLKS_PER_BIT times.
  always @(posedge clk or negedge reset) begin
    for (int g = 0; g < NDUT; g++) begin
      if (!reset) begin
        mq[g].delete();
      end else if (mq[g].size() != 0) begin
        void'(mq[g].pop_front());
      end else if (valid) begin
        bit p;
        p = 1'b0;
        lv.delete();
        lv.push_back(1'b0);
        for (int b = 0; b < W_A[g]; b++) begin
          lv.push_back(data[b]);
          p = p ^ data[b];
        end
        if (P_A[g] != 0) lv.push_back(p);
        lv.push_back(1'b1);
        foreach (lv[i]) begin
          for (int r = 0; r < C_A[g]; r++) mq[g].push_back(lv[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int g = 0; g < NDUT; g++) begin
        bit e_tx;
        bit e_busy;
        e_busy = (mq[g].size() != 0);
        e_tx   = e_busy ? mq[g][0] : 1'b1;
        chk($sformatf("model dut%0d tx", g), int'(tx[g]), int'(e_tx));
        chk($sformatf("model dut%0d busy", g), int'(busy[g]), int'(e_busy));
        chk($sformatf("model dut%0d ready", g), int'(ready[g]), int'(!e_busy));
      end
    end
  end

  initial begin
    logic [9:0]   want_line;
    logic [7:0]   v;
    logic [127:0] lb0;
    logic [127:0] lb1;
    int           busy0;
    int           busy1;
    int           s1;
    int           s2;
    logic         prev_ready;

    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("in reset tx", int'(tx[0]), 1);
    chk("in reset ready", int'(ready[0]), 1);
    chk("in reset busy", int'(busy[0]), 0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle tx", int'(tx[0]), 1);
      chk("idle ready", int'(ready[0]), 1);
      chk("idle busy", int'(busy[0]), 0);
    end

    // Single A5 frame, with a 8'hFF word offered mid-frame that must be ignored.
    @(negedge clk); data = 8'hA5; valid = 1'b1;
    @(negedge clk); valid = 1'b0; data = 8'h00;
    chk("accept busy", int'(busy[0]), 1);
    chk("accept ready", int'(ready[0]), 0);
    busy0 = 0;
    busy1 = 0;
    for (int k = 0; k < 48; k++) begin
      lb0[k] = tx[0];
      lb1[k] = tx[1];
      busy0 += int'(busy[0]);
      busy1 += int'(busy[1]);
      if (k == 40) chk("ready after frame", int'(ready[0]), 1);
      if (k == 12) begin data = 8'hFF; valid = 1'b1; end
      if (k == 13) begin valid = 1'b0; data = 8'h00; end
      @(negedge clk);
    end
    want_line = 10'b1_10100101_0;
    for (int j = 0; j < 10; j++) chk($sformatf("A5 line bit %0d", j), int'(lb0[4*j+2]), int'(want_line[j]));
    chk("A5 frame cycles", busy0, 40);
    chk("A5 parity frame cycles", busy1, 44);
    chk("A5 parity bit", int'(lb1[38]), 0);
    chk("A5 parity stop", int'(lb1[42]), 1);

    @(negedge clk); data = 8'h01; valid = 1'b1;
    @(negedge clk); valid = 1'b0; data = 8'h00;
    for (int k = 0; k < 48; k++) begin
      lb1[k] = tx[1];
      @(negedge clk);
    end
    chk("01 data bit0", int'(lb1[6]), 1);
    chk("01 parity bit", int'(lb1[38]), 1);

    // Back-to-back with valid held high.
    @(negedge clk); data = 8'h3C; valid = 1'b1;
    @(negedge clk); data = 8'hC3;
    s1 = -1;
    s2 = -1;
    prev_ready = 1'b1;
    for (int k = 0; k < 90; k++) begin
      if (prev_ready && !ready[0]) begin
        if (s1 < 0) s1 = k;
        else if (s2 < 0) s2 = k;
      end
      prev_ready = ready[0];
      lb0[k] = tx[0];
      if (k == 41) valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b first start", s1, 0);
    chk("b2b start gap", s2 - s1, 41);
    chk("b2b second start level", int'(lb0[41]), 0);
    v = 8'h3C;
    for (int j = 0; j < 8; j++) chk($sformatf("3C bit %0d", j), int'(lb0[6+4*j]), int'(v[j]));
    v = 8'hC3;
    for (int j = 0; j < 8; j++) chk($sformatf("C3 bit %0d", j), int'(lb0[47+4*j]), int'(v[j]));

    // Asynchronous reset during data bit 3, then a clean 5A frame.
    @(negedge clk); data = 8'hA5; valid = 1'b1;
    @(negedge clk); valid = 1'b0; data = 8'h00;
    repeat (17) @(negedge clk);
    chk("bit3 level before reset", int'(tx[0]), 0);
    #2 reset = 1'b0;
    #1;
    chk("async reset tx", int'(tx[0]), 1);
    chk("async reset busy", int'(busy[0]), 0);
    chk("async reset ready", int'(ready[0]), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); data = 8'h5A; valid = 1'b1;
    @(negedge clk); valid = 1'b0; data = 8'h00;
    for (int k = 0; k < 44; k++) begin
      lb0[k] = tx[0];
      @(negedge clk);
    end
    want_line = 10'b1_01011010_0;
    for (int j = 0; j < 10; j++) chk($sformatf("5A line bit %0d", j), int'(lb0[4*j+2]), int'(want_line[j]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
